// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and FSM state types.
// Shared by vga_phase_counter and vga_timing_ctrl.
package vga_timing_pkg;

  localparam int H_ACTIVE_C = 640;
  localparam int H_FRONT_C  = 16;
  localparam int H_SYNC_C   = 96;
  localparam int H_BACK_C   = 48;
  localparam int H_TOTAL_C  = H_ACTIVE_C + H_FRONT_C
                            + H_SYNC_C + H_BACK_C;
  localparam int H_SYNC_START_C = H_ACTIVE_C + H_FRONT_C;
  localparam int H_SYNC_END_C   = H_SYNC_START_C + H_SYNC_C - 1;

  localparam int V_ACTIVE_C = 480;
  localparam int V_FRONT_C  = 10;
  localparam int V_SYNC_C   = 2;
  localparam int V_BACK_C   = 33;
  localparam int V_TOTAL_C  = V_ACTIVE_C + V_FRONT_C
                            + V_SYNC_C + V_BACK_C;
  localparam int V_SYNC_START_C = V_ACTIVE_C + V_FRONT_C;
  localparam int V_SYNC_END_C   = V_SYNC_START_C + V_SYNC_C - 1;

  localparam logic SYNC_POL_C = 1'b0;

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_RUN,
    CTRL_DRAIN
  } ctrl_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

endpackage

// File: rtl/vga_phase_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Also exposes next-state values so the parent can register decoded outputs.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_C,
  parameter int FRONT  = H_FRONT_C,
  parameter int SYNC   = H_SYNC_C,
  parameter int BACK   = H_BACK_C
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       adv,
  input  logic       clr,
  output logic [9:0] count,
  output logic [9:0] count_nxt,
  output phase_t     phase,
  output phase_t     phase_nxt,
  output logic       wrap
);

  localparam logic [9:0] A_END = 10'(ACTIVE - 1);
  localparam logic [9:0] F_END = 10'(ACTIVE + FRONT - 1);
  localparam logic [9:0] S_END = 10'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [9:0] T_END =
    10'(ACTIVE + FRONT + SYNC + BACK - 1);

  logic [9:0] count_q, count_d;
  phase_t     phase_q, phase_d;

  assign wrap = adv & (count_q == T_END);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (clr) begin
      count_d = '0;
      phase_d = PH_ACTIVE;
    end else if (adv) begin
      count_d = wrap ? '0 : count_q + 10'd1;
      unique case (phase_q)
        PH_ACTIVE: if (count_q == A_END) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == F_END) phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == S_END) phase_d = PH_BACK;
        PH_BACK:   if (count_q == T_END) phase_d = PH_ACTIVE;
        default:   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;
  assign phase     = phase_q;
  assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: Clk/2 pixel tick, frame-aligned start/stop on En.
// VGA_TIMING_OUTREG_EN adds one register stage on the raster outputs.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_C,
  parameter int   H_FRONT  = H_FRONT_C,
  parameter int   H_SYNC   = H_SYNC_C,
  parameter int   H_BACK   = H_BACK_C,
  parameter int   V_ACTIVE = V_ACTIVE_C,
  parameter int   V_FRONT  = V_FRONT_C,
  parameter int   V_SYNC   = V_SYNC_C,
  parameter int   V_BACK   = V_BACK_C,
  parameter logic SYNC_POL = SYNC_POL_C
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start,
  output logic       busy
);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);

  ctrl_t      ctrl_q, ctrl_d;
  logic       div_q, div_d;
  logic       idle;
  logic       h_wrap, v_wrap;
  logic [9:0] h_cnt, h_cnt_n, v_cnt, v_cnt_n;
  phase_t     h_ph, h_ph_n, v_ph, v_ph_n;
  logic       run_n, tick_n;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic von_q, von_d;
  logic le_q, le_d;
  logic fs_q, fs_d;

  assign idle     = (ctrl_q == CTRL_IDLE);
  assign pix_tick = div_q & ~idle;
  assign busy     = ~idle;

  vga_phase_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
    .SYNC(H_SYNC),     .BACK(H_BACK)
  ) u_h (
    .Clk(Clk), .Reset(Reset),
    .adv(pix_tick), .clr(idle),
    .count(h_cnt), .count_nxt(h_cnt_n),
    .phase(h_ph), .phase_nxt(h_ph_n),
    .wrap(h_wrap)
  );

  vga_phase_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
    .SYNC(V_SYNC),     .BACK(V_BACK)
  ) u_v (
    .Clk(Clk), .Reset(Reset),
    .adv(h_wrap), .clr(idle),
    .count(v_cnt), .count_nxt(v_cnt_n),
    .phase(v_ph), .phase_nxt(v_ph_n),
    .wrap(v_wrap)
  );

  // RUN vs DRAIN only records En; it is acted on at the frame wrap.
  always_comb begin
    ctrl_d = ctrl_q;
    unique case (ctrl_q)
      CTRL_IDLE: if (En) ctrl_d = CTRL_RUN;
      CTRL_RUN, CTRL_DRAIN: begin
        if (v_wrap) ctrl_d = En ? CTRL_RUN : CTRL_IDLE;
        else        ctrl_d = En ? CTRL_RUN : CTRL_DRAIN;
      end
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  assign div_d  = idle ? 1'b0 : ~div_q;
  assign run_n  = (ctrl_d != CTRL_IDLE);
  assign tick_n = run_n & div_d;

  always_comb begin
    hsync_d = (run_n && h_ph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (run_n && v_ph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    von_d   = run_n && h_ph_n == PH_ACTIVE && v_ph_n == PH_ACTIVE;
    le_d    = tick_n && h_cnt_n == H_LAST;
    fs_d    = tick_n && h_cnt_n == '0 && v_cnt_n == '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q  <= CTRL_IDLE;
      div_q   <= 1'b0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      von_q   <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_TIMING_OUTREG_EN
  // Delay stage lines the raster up with a 1-cycle RAM read.
  logic [24:0] out_q, out_d, out_rst;

  assign out_d   = {hsync_q, vsync_q, von_q, le_q, fs_q,
                    h_cnt, v_cnt};
  assign out_rst = {~SYNC_POL, ~SYNC_POL, 3'b000, 20'd0};

  always_ff @(posedge Clk) begin
    if (Reset) out_q <= out_rst;
    else       out_q <= out_d;
  end

  assign {hsync, vsync, video_on, line_end, frame_start,
          pixel_x, pixel_y} = out_q;
`else
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = von_q;
  assign line_end    = le_q;
  assign frame_start = fs_q;
  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
`endif

endmodule
